// File: rtl/sap_pkg.sv
// sap_pkg: opcodes, control-word bit indices, flag indices and FSM states shared by the SAP-1 sequencer.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'he;
    localparam logic [3:0] OP_HLT = 4'hf;

    localparam int CW_W            = 16;
    localparam int CW_REG_A_IN     = 15;
    localparam int CW_REG_A_OUT    = 14;
    localparam int CW_REG_B_IN     = 13;
    localparam int CW_REG_B_OUT    = 12;
    localparam int CW_ALU_OUT      = 11;
    localparam int CW_ALU_SUB      = 10;
    localparam int CW_INSTR_IN     = 9;
    localparam int CW_INSTR_OUT    = 8;
    localparam int CW_MAR_IN       = 7;
    localparam int CW_RAM_IN       = 6;
    localparam int CW_RAM_OUT      = 5;
    localparam int CW_REG_OUT_IN   = 4;
    localparam int CW_PC_INC       = 3;
    localparam int CW_PC_OUT       = 2;
    localparam int CW_PC_JMP       = 1;
    localparam int CW_REG_FLAGS_IN = 0;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    function automatic logic [CW_W-1:0] cw_bit(input int idx);
        return CW_W'(1) << idx;
    endfunction

endpackage

// File: rtl/sap_microcode_rom.sv
// sap_microcode_rom: combinational {opcode, step, flags} -> control word, last-step and halt decode.
module sap_microcode_rom
    import sap_pkg::*;
(
    input  logic [3:0]      i_opcode,
    input  logic [3:0]      i_step,
    input  logic [1:0]      i_flags,
    output logic [CW_W-1:0] o_cw,
    output logic            o_last,
    output logic            o_halt
);

    logic [CW_W-1:0] w_jump;
    logic            w_has_exec;

    assign w_jump     = cw_bit(CW_INSTR_OUT) | cw_bit(CW_PC_JMP);
    assign w_has_exec = i_opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                                         OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT};

    always_comb begin
        o_cw   = '0;
        o_last = 1'b1;
        o_halt = 1'b0;
        case (i_step)
            4'd0: begin
                o_cw   = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_IN);
                o_last = 1'b0;
            end
            4'd1: begin
                o_cw   = cw_bit(CW_RAM_OUT) | cw_bit(CW_INSTR_IN) | cw_bit(CW_PC_INC);
                o_last = !w_has_exec;
            end
            4'd2: begin
                case (i_opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        o_cw   = cw_bit(CW_INSTR_OUT) | cw_bit(CW_MAR_IN);
                        o_last = 1'b0;
                    end
                    OP_LDI:  o_cw = cw_bit(CW_INSTR_OUT) | cw_bit(CW_REG_A_IN);
                    OP_JMP:  o_cw = w_jump;
                    OP_JC:   o_cw = i_flags[FLAG_CARRY] ? w_jump : '0;
                    OP_JZ:   o_cw = i_flags[FLAG_ZERO] ? w_jump : '0;
                    OP_OUT:  o_cw = cw_bit(CW_REG_A_OUT) | cw_bit(CW_REG_OUT_IN);
                    OP_HLT:  o_halt = 1'b1;
                    default: ;
                endcase
            end
            4'd3: begin
                case (i_opcode)
                    OP_LDA:  o_cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_REG_A_IN);
                    OP_STA:  o_cw = cw_bit(CW_REG_A_OUT) | cw_bit(CW_RAM_IN);
                    OP_ADD, OP_SUB: begin
                        o_cw   = cw_bit(CW_RAM_OUT) | cw_bit(CW_REG_B_IN);
                        o_last = 1'b0;
                    end
                    default: ;
                endcase
            end
            4'd4: begin
                if (i_opcode == OP_ADD || i_opcode == OP_SUB)
                    o_cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_REG_A_IN) | cw_bit(CW_REG_FLAGS_IN)
                         | ((i_opcode == OP_SUB) ? cw_bit(CW_ALU_SUB) : '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_sequencer.sv
// sap_sequencer: SAP-1 microstep sequencer (IDLE/RUN/HALTED) driving datapath control lines.
// SAP_SINGLE_STEP_EN adds a step_en input that gates every RUN advance and the IDLE->RUN start.
module sap_sequencer
    import sap_pkg::*;
#(
    parameter int MAX_STEPS = 5,
    parameter int FLAG_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              debug,
    input  logic              pr_mode,
`ifdef SAP_SINGLE_STEP_EN
    input  logic              step_en,
`endif
    input  logic [3:0]        opcode,
    input  logic [FLAG_W-1:0] flags,
    output logic              halt,
    output logic              reg_a_in,
    output logic              reg_a_out,
    output logic              reg_b_in,
    output logic              reg_b_out,
    output logic              alu_out,
    output logic              alu_sub,
    output logic              instr_in,
    output logic              instr_out,
    output logic              mar_in,
    output logic              ram_in,
    output logic              ram_out,
    output logic              reg_out_in,
    output logic              pc_inc,
    output logic              pc_out,
    output logic              pc_jmp,
    output logic              reg_flags_in,
    output logic [3:0]        step_out
);

    state_t          r_state, w_state_nx;
    logic [3:0]      r_step, w_step_nx;
    logic [CW_W-1:0] w_cw, w_ctl;
    logic            w_last, w_hlt, w_adv, w_unused;

`ifdef SAP_SINGLE_STEP_EN
    assign w_adv = step_en;
`else
    assign w_adv = 1'b1;
`endif

    // debug only steers an off-chip trace; upper flag bits carry no meaning here
    assign w_unused = ^{debug, flags[FLAG_W-1:2]};

    sap_microcode_rom u_rom (
        .i_opcode (opcode),
        .i_step   (r_step),
        .i_flags  (flags[FLAG_ZERO:FLAG_CARRY]),
        .o_cw     (w_cw),
        .o_last   (w_last),
        .o_halt   (w_hlt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_step  <= w_step_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_step_nx  = r_step;
        if (pr_mode) begin
            w_state_nx = ST_IDLE;
            w_step_nx  = '0;
        end else if (w_adv) begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_RUN;
                    w_step_nx  = '0;
                end
                ST_RUN: begin
                    w_state_nx = w_hlt ? ST_HALTED : ST_RUN;
                    w_step_nx  = (w_hlt || w_last || r_step == 4'(MAX_STEPS - 1)) ? '0 : r_step + 4'd1;
                end
                default: w_step_nx = '0;
            endcase
        end
    end

    assign w_ctl    = (r_state == ST_RUN) ? w_cw : '0;
    assign halt     = (r_state == ST_HALTED) || (r_state == ST_RUN && w_hlt);
    assign step_out = r_step;

    assign reg_a_in     = w_ctl[CW_REG_A_IN];
    assign reg_a_out    = w_ctl[CW_REG_A_OUT];
    assign reg_b_in     = w_ctl[CW_REG_B_IN];
    assign reg_b_out    = w_ctl[CW_REG_B_OUT];
    assign alu_out      = w_ctl[CW_ALU_OUT];
    assign alu_sub      = w_ctl[CW_ALU_SUB];
    assign instr_in     = w_ctl[CW_INSTR_IN];
    assign instr_out    = w_ctl[CW_INSTR_OUT];
    assign mar_in       = w_ctl[CW_MAR_IN];
    assign ram_in       = w_ctl[CW_RAM_IN];
    assign ram_out      = w_ctl[CW_RAM_OUT];
    assign reg_out_in   = w_ctl[CW_REG_OUT_IN];
    assign pc_inc       = w_ctl[CW_PC_INC];
    assign pc_out       = w_ctl[CW_PC_OUT];
    assign pc_jmp       = w_ctl[CW_PC_JMP];
    assign reg_flags_in = w_ctl[CW_REG_FLAGS_IN];

endmodule

// File: tb/tb_sap_sequencer.sv
// tb_sap_sequencer: table-driven vectors plus hand sequences for reset, pr_mode abort and halt.
module tb_sap_sequencer;

    localparam logic [16:0] HL = 17'h10000, AI = 17'h08000, AO = 17'h04000, BI = 17'h02000;
    localparam logic [16:0] BO = 17'h01000, EO = 17'h00800, SU = 17'h00400, II = 17'h00200;
    localparam logic [16:0] IO = 17'h00100, MI = 17'h00080, RI = 17'h00040, RO = 17'h00020;
    localparam logic [16:0] OI = 17'h00010, CE = 17'h00008, CO = 17'h00004, JP = 17'h00002;
    localparam logic [16:0] FI = 17'h00001;
    localparam logic [16:0] T0 = CO | MI, T1 = RO | II | CE;

    logic clk = 1'b0, rst = 1'b0, debug = 1'b0, pr_mode = 1'b0;
    logic [3:0] opcode = 4'h0, flags = 4'h0;
`ifdef SAP_SINGLE_STEP_EN
    logic step_en = 1'b1;
`endif
    logic halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub, instr_in, instr_out;
    logic mar_in, ram_in, ram_out, reg_out_in, pc_inc, pc_out, pc_jmp, reg_flags_in;
    logic [3:0] step_out;
    logic [16:0] ctl;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  fl;
        logic        pr;
        logic [3:0]  st;
        logic [16:0] ctl;
    } vec_t;
    vec_t tv[$];

    sap_sequencer dut (
        .clk(clk), .rst(rst), .debug(debug), .pr_mode(pr_mode),
`ifdef SAP_SINGLE_STEP_EN
        .step_en(step_en),
`endif
        .opcode(opcode), .flags(flags), .halt(halt),
        .reg_a_in(reg_a_in), .reg_a_out(reg_a_out), .reg_b_in(reg_b_in), .reg_b_out(reg_b_out),
        .alu_out(alu_out), .alu_sub(alu_sub), .instr_in(instr_in), .instr_out(instr_out),
        .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out), .reg_out_in(reg_out_in),
        .pc_inc(pc_inc), .pc_out(pc_out), .pc_jmp(pc_jmp), .reg_flags_in(reg_flags_in),
        .step_out(step_out)
    );

    always #5 clk = ~clk;

    assign ctl = {halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub, instr_in,
                  instr_out, mar_in, ram_in, ram_out, reg_out_in, pc_inc, pc_out, pc_jmp, reg_flags_in};

    task automatic chk(input string nm, input logic [3:0] es, input logic [16:0] ec);
        n_chk += 3;
        if (ctl !== ec) begin
            n_fail++;
            $display("FAIL %s: controls got %h want %h", nm, ctl, ec);
        end
        if (step_out !== es) begin
            n_fail++;
            $display("FAIL %s: step_out got %0d want %0d", nm, step_out, es);
        end
        if ($countones({reg_a_out, reg_b_out, alu_out, instr_out, ram_out, pc_out}) > 1) begin
            n_fail++;
            $display("FAIL %s: bus drivers got %h want at most one", nm, ctl);
        end
    endtask

    task automatic cyc(input string nm, input logic [3:0] es, input logic [16:0] ec);
        @(negedge clk);
        chk(nm, es, ec);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [3:0] op, input logic [3:0] fl, input logic [3:0] st, input logic [16:0] c);
        tv.push_back('{op: op, fl: fl, pr: 1'b0, st: st, ctl: c});
    endtask

    task automatic add_fetch(input logic [3:0] op, input logic [3:0] fl);
        add(op, fl, 4'd0, T0);
        add(op, fl, 4'd1, T1);
    endtask

    initial begin
        add(4'h0, 4'h0, 4'd0, 17'h0);
        add_fetch(4'h2, 4'h0); add(4'h2, 4'h0, 4'd2, IO | MI); add(4'h2, 4'h0, 4'd3, RO | BI);
        add(4'h2, 4'h0, 4'd4, EO | AI | FI);
        add_fetch(4'h3, 4'h0); add(4'h3, 4'h0, 4'd2, IO | MI); add(4'h3, 4'h0, 4'd3, RO | BI);
        add(4'h3, 4'h0, 4'd4, EO | AI | FI | SU);
        add_fetch(4'h7, 4'h1); add(4'h7, 4'h1, 4'd2, IO | JP);
        add_fetch(4'h7, 4'h0); add(4'h7, 4'h0, 4'd2, 17'h0);
        add_fetch(4'h8, 4'h2); add(4'h8, 4'h2, 4'd2, IO | JP);
        add_fetch(4'h8, 4'h1); add(4'h8, 4'h1, 4'd2, 17'h0);
        add_fetch(4'h0, 4'h0);
        add_fetch(4'ha, 4'h3);
        add_fetch(4'h1, 4'h0); add(4'h1, 4'h0, 4'd2, IO | MI); add(4'h1, 4'h0, 4'd3, RO | AI);
        add_fetch(4'h4, 4'h0); add(4'h4, 4'h0, 4'd2, IO | MI); add(4'h4, 4'h0, 4'd3, AO | RI);
        add_fetch(4'h5, 4'h0); add(4'h5, 4'h0, 4'd2, IO | AI);
        add_fetch(4'h6, 4'h0); add(4'h6, 4'h0, 4'd2, IO | JP);
        add_fetch(4'he, 4'h0); add(4'he, 4'h0, 4'd2, AO | OI);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset", 4'd0, 17'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            opcode  = tv[i].op;
            flags   = tv[i].fl;
            pr_mode = tv[i].pr;
            cyc($sformatf("vec%0d", i), tv[i].st, tv[i].ctl);
        end

        opcode = 4'h1; flags = 4'h0;
        cyc("lda_t0", 4'd0, T0);
        cyc("lda_t1", 4'd1, T1);
        cyc("lda_t2", 4'd2, IO | MI);
        @(negedge clk);
        chk("lda_t3", 4'd3, RO | AI);
        pr_mode = 1'b1;
        @(posedge clk);
        #1 pr_mode = 1'b0;
        cyc("pr_idle", 4'd0, 17'h0);
        cyc("pr_restart_t0", 4'd0, T0);
        cyc("pr_restart_t1", 4'd1, T1);

        rst = 1'b0;
        #1 chk("rst_async", 4'd0, 17'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        cyc("rst_idle", 4'd0, 17'h0);
        cyc("rst_t0", 4'd0, T0);

        opcode = 4'hf;
        cyc("hlt_t1", 4'd1, T1);
        cyc("hlt_t2", 4'd2, HL);
        for (int i = 0; i < 20; i++) cyc($sformatf("halted%0d", i), 4'd0, HL);
        @(negedge clk);
        chk("halted_pr", 4'd0, HL);
        pr_mode = 1'b1;
        @(posedge clk);
        #1 pr_mode = 1'b0;
        cyc("halt_to_idle", 4'd0, 17'h0);
        cyc("halt_restart", 4'd0, T0);

`ifdef SAP_SINGLE_STEP_EN
        begin
            logic [16:0] words [4];
            int idx;
            words[0] = T0; words[1] = T1; words[2] = IO | MI; words[3] = RO | AI;
            opcode = 4'h1;
            pr_mode = 1'b1;
            step_en = 1'b0;
            @(posedge clk);
            #1 pr_mode = 1'b0;
            idx = -1;
            for (int k = 0; k < 20; k++) begin
                step_en = (k % 4 == 3);
                @(negedge clk);
                chk($sformatf("ss%0d", k), (idx < 0) ? 4'd0 : 4'(idx), (idx < 0) ? 17'h0 : words[idx]);
                @(posedge clk);
                if (step_en) idx = (idx + 1) % 4;
                #1;
            end
            step_en = 1'b1;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
